// File: rtl/mem_bist_ctrl.sv
// mem_bist_ctrl
//   March-test sequencer for a register memory with separate write and read
//   ports. On start_i it writes the background pattern P upwards, then for each
//   address upwards reads and checks P and overwrites with ~P, then for each
//   address downwards reads and checks ~P. It reports pass/fail, the first
//   failing address and a saturating mismatch count. Write and read strobes
//   are never high in the same cycle.
//
// Build option:
//   MEM_BIST_ABORT_EN  when defined, the first mismatch ends the test at once.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start_i           begin a test (sampled only while idle)
//   pattern_i         background pattern P, latched on accepted start
//   busy_o, done_o    test in progress / one-cycle completion pulse
//   pass_o            result of last test, valid from done_o
//   fail_addr_o       first mismatching address of the test
//   err_cnt_o         mismatch count, saturating at 255
//   mem_wr_o, mem_rd_o, mem_data_o, mem_wr_addr_o, mem_rd_addr_o
//                     memory port drive, decoded from registers only
//   mem_rdata_i       registered read data from the memory
//
// state | meaning
// IDLE  | waiting for start_i
// W_UP  | write P, address ascending
// R_UP  | read address, ascending pass
// CW_UP | check P, write ~P at same address
// R_DN  | read address, descending pass
// C_DN  | check ~P
// DONE  | one-cycle completion, result visible
module mem_bist_ctrl #(
   parameter int WIDTH = 2,
   parameter int PSIZE = 2,
   parameter int DEPTH = 2**PSIZE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] pattern_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic [PSIZE-1:0] fail_addr_o,
   output logic [7:0]       err_cnt_o,
   output logic             mem_wr_o,
   output logic             mem_rd_o,
   output logic [WIDTH-1:0] mem_data_o,
   output logic [PSIZE-1:0] mem_wr_addr_o,
   output logic [PSIZE-1:0] mem_rd_addr_o,
   input  logic [WIDTH-1:0] mem_rdata_i
);

`ifdef MEM_BIST_ABORT_EN
   localparam bit ABORT_EN = 1'b1;
`else
   localparam bit ABORT_EN = 1'b0;
`endif

   localparam logic [PSIZE-1:0] ADDR_LAST = PSIZE'(DEPTH - 1);
   localparam logic [PSIZE-1:0] ADDR_ONE  = PSIZE'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_W_UP  = 3'd1,
      S_R_UP  = 3'd2,
      S_CW_UP = 3'd3,
      S_R_DN  = 3'd4,
      S_C_DN  = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t           state_q, state_d;
   logic [PSIZE-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic [7:0]       err_cnt_q, err_cnt_d;
   logic [PSIZE-1:0] fail_addr_q, fail_addr_d;
   logic             pass_q, pass_d;

   logic             cmp_en;
   logic [WIDTH-1:0] cmp_exp;
   logic             mismatch;

   // Read data belongs to the read issued in the previous state.
   assign cmp_en   = (state_q == S_CW_UP) || (state_q == S_C_DN);
   assign cmp_exp  = (state_q == S_CW_UP) ? pat_q : ~pat_q;
   assign mismatch = cmp_en && (mem_rdata_i != cmp_exp);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         pat_q       <= '0;
         err_cnt_q   <= '0;
         fail_addr_q <= '0;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         pat_q       <= pat_d;
         err_cnt_q   <= err_cnt_d;
         fail_addr_q <= fail_addr_d;
         pass_q      <= pass_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      pat_d       = pat_q;
      err_cnt_d   = err_cnt_q;
      fail_addr_d = fail_addr_q;
      pass_d      = pass_q;

      if (mismatch) begin
         if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end
         if (err_cnt_q == 8'd0) begin
            fail_addr_d = addr_q;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d     = S_W_UP;
               addr_d      = '0;
               pat_d       = pattern_i;
               err_cnt_d   = '0;
               fail_addr_d = '0;
               pass_d      = 1'b0;
            end
         end
         S_W_UP: begin
            if (addr_q == ADDR_LAST) begin
               state_d = S_R_UP;
               addr_d  = '0;
            end else begin
               addr_d  = addr_q + ADDR_ONE;
            end
         end
         S_R_UP: state_d = S_CW_UP;
         S_CW_UP: begin
            if (ABORT_EN && mismatch) begin
               state_d = S_DONE;
            end else if (addr_q == ADDR_LAST) begin
               state_d = S_R_DN;
            end else begin
               state_d = S_R_UP;
               addr_d  = addr_q + ADDR_ONE;
            end
         end
         S_R_DN: state_d = S_C_DN;
         S_C_DN: begin
            if (ABORT_EN && mismatch) begin
               state_d = S_DONE;
            end else if (addr_q == '0) begin
               state_d = S_DONE;
            end else begin
               state_d = S_R_DN;
               addr_d  = addr_q - ADDR_ONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Resolve the verdict on entry to DONE so pass_o is valid with done_o.
      if ((state_d == S_DONE) && (state_q != S_DONE)) begin
         pass_d = (err_cnt_d == 8'd0);
      end
   end

   always_comb begin
      mem_wr_o      = 1'b0;
      mem_rd_o      = 1'b0;
      mem_data_o    = '0;
      mem_wr_addr_o = '0;
      mem_rd_addr_o = '0;
      case (state_q)
         S_W_UP: begin
            mem_wr_o      = 1'b1;
            mem_wr_addr_o = addr_q;
            mem_data_o    = pat_q;
         end
         S_CW_UP: begin
            mem_wr_o      = 1'b1;
            mem_wr_addr_o = addr_q;
            mem_data_o    = ~pat_q;
         end
         S_R_UP, S_R_DN: begin
            mem_rd_o      = 1'b1;
            mem_rd_addr_o = addr_q;
         end
         default: ;
      endcase
   end

   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = (state_q == S_DONE);
   assign pass_o      = pass_q;
   assign fail_addr_o = fail_addr_q;
   assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl: a 4-word DUT and a 256-word DUT, each
// wired to a behavioural register memory with per-address stuck-at-0 masks.
module tb_mem_bist_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // small instance
   logic       start;
   logic [1:0] pattern;
   logic       busy, done, pass;
   logic [1:0] fail_addr;
   logic [7:0] err_cnt;
   logic       mem_wr, mem_rd;
   logic [1:0] mem_data, mem_wr_addr, mem_rd_addr, mem_rdata;
   logic [1:0] mem_n [4];
   logic [1:0] stuck_n [4];

   mem_bist_ctrl #(.WIDTH(2), .PSIZE(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .pattern_i(pattern),
      .busy_o(busy), .done_o(done), .pass_o(pass), .fail_addr_o(fail_addr),
      .err_cnt_o(err_cnt), .mem_wr_o(mem_wr), .mem_rd_o(mem_rd),
      .mem_data_o(mem_data), .mem_wr_addr_o(mem_wr_addr),
      .mem_rd_addr_o(mem_rd_addr), .mem_rdata_i(mem_rdata)
   );

   always @(posedge clk) begin
      if (mem_wr) mem_n[mem_wr_addr] <= mem_data & ~stuck_n[mem_wr_addr];
      if (mem_rd) mem_rdata <= mem_n[mem_rd_addr];
   end

   // wide instance for saturation
   logic       start_w;
   logic [1:0] pattern_w;
   logic       busy_w, done_w, pass_w;
   logic [7:0] fail_addr_w;
   logic [7:0] err_cnt_w;
   logic       mem_wr_w, mem_rd_w;
   logic [1:0] mem_data_w, mem_rdata_w;
   logic [7:0] mem_wr_addr_w, mem_rd_addr_w;
   logic [1:0] mem_w [256];
   logic [1:0] stuck_w [256];

   mem_bist_ctrl #(.WIDTH(2), .PSIZE(8)) u_dut_w (
      .clk(clk), .rst_n(rst_n), .start_i(start_w), .pattern_i(pattern_w),
      .busy_o(busy_w), .done_o(done_w), .pass_o(pass_w), .fail_addr_o(fail_addr_w),
      .err_cnt_o(err_cnt_w), .mem_wr_o(mem_wr_w), .mem_rd_o(mem_rd_w),
      .mem_data_o(mem_data_w), .mem_wr_addr_o(mem_wr_addr_w),
      .mem_rd_addr_o(mem_rd_addr_w), .mem_rdata_i(mem_rdata_w)
   );

   always @(posedge clk) begin
      if (mem_wr_w) mem_w[mem_wr_addr_w] <= mem_data_w & ~stuck_w[mem_wr_addr_w];
      if (mem_rd_w) mem_rdata_w <= mem_w[mem_rd_addr_w];
   end

   int n_chk = 0;
   int n_err = 0;
   int proto_viol = 0;

   always @(negedge clk) begin
      if ((mem_wr && mem_rd) || (mem_wr_w && mem_rd_w)) proto_viol++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // write-port log of cycles 1..4 of the last run
   logic       wlog_wr   [5];
   logic [1:0] wlog_addr [5];
   logic [1:0] wlog_data [5];
   logic       wlog_busy [5];

   // Called at a negedge with the DUT idle; returns at the negedge of the
   // DONE cycle (done_cyc = cycle number, start accepted at cycle 0).
   task automatic run_bist(input logic [1:0] p, input bit poke, output int done_cyc);
      start   = 1'b1;
      pattern = p;
      @(negedge clk);
      start    = 1'b0;
      done_cyc = -1;
      for (int c = 1; c <= 60; c++) begin
         if (c <= 4) begin
            wlog_wr[c]   = mem_wr;
            wlog_addr[c] = mem_wr_addr;
            wlog_data[c] = mem_data;
            wlog_busy[c] = busy;
         end
         if (done) begin
            done_cyc = c;
            break;
         end
         start = (poke && c == 7);
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   int  dc;
   int  exp_fault_done;
   logic [7:0] exp_sat;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 4; i++) stuck_n[i] = 2'b00;
      for (int i = 0; i < 256; i++) stuck_w[i] = 2'b01;
      rst_n = 1'b0; start = 1'b0; pattern = 2'b00;
      start_w = 1'b0; pattern_w = 2'b00;
      repeat (3) @(negedge clk);

      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_err", err_cnt, 0);
      chk("rst_fail_addr", fail_addr, 0);
      chk("rst_strobes", {mem_wr, mem_rd}, 0);
      chk("rst_data_addr", {mem_data, mem_wr_addr, mem_rd_addr}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // baseline, pattern 01
      run_bist(2'b01, 1'b0, dc);
      chk("base_done_cyc", dc, 21);
      chk("base_pass", pass, 1);
      chk("base_err", err_cnt, 0);
      chk("base_busy_done", busy, 1);
      for (int c = 1; c <= 4; c++) begin
         chk("base_wr", wlog_wr[c], 1);
         chk("base_wr_addr", wlog_addr[c], c - 1);
         chk("base_wr_data", wlog_data[c], 2'b01);
         chk("base_busy", wlog_busy[c], 1);
      end
      @(negedge clk);
      chk("base_idle_busy", busy, 0);
      chk("base_idle_done", done, 0);
      chk("base_pass_held", pass, 1);

      // start pulsed mid-test is ignored
      run_bist(2'b10, 1'b1, dc);
      chk("poke_done_cyc", dc, 21);
      chk("poke_pass", pass, 1);
      @(negedge clk);
      chk("poke_idle", busy, 0);

      // stuck-at-0 bit0 at addr 2: only the up-compare fails
      stuck_n[2] = 2'b01;
      run_bist(2'b01, 1'b0, dc);
      chk("sa2_done_cyc", dc, 21);
      chk("sa2_pass", pass, 0);
      chk("sa2_fail_addr", fail_addr, 2);
      chk("sa2_err", err_cnt, 1);
      @(negedge clk);
      chk("sa2_pass_held", pass, 0);
      stuck_n[2] = 2'b00;

      // stuck at addr 1; abort build ends at cycle 9
`ifdef MEM_BIST_ABORT_EN
      exp_fault_done = 9;
      exp_sat = 8'd1;
`else
      exp_fault_done = 21;
      exp_sat = 8'd255;
`endif
      stuck_n[1] = 2'b01;
      run_bist(2'b01, 1'b0, dc);
      chk("sa1_done_cyc", dc, exp_fault_done);
      chk("sa1_pass", pass, 0);
      chk("sa1_fail_addr", fail_addr, 1);
      chk("sa1_err", err_cnt, 1);
      @(negedge clk);
      stuck_n[1] = 2'b00;

      // reset at cycle 10, with a mismatch already counted at cycle 6
      stuck_n[0] = 2'b01;
      start = 1'b1; pattern = 2'b01;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mrst_busy", busy, 0);
      chk("mrst_done", done, 0);
      chk("mrst_strobes", {mem_wr, mem_rd}, 0);
      chk("mrst_err", err_cnt, 0);
      chk("mrst_pass", pass, 0);
      rst_n = 1'b1;
      stuck_n[0] = 2'b00;
      @(negedge clk);
      run_bist(2'b11, 1'b0, dc);
      chk("mrst_restart_done", dc, 21);
      chk("mrst_restart_pass", pass, 1);
      @(negedge clk);

      // random patterns, fault-free
      for (int r = 0; r < 100; r++) begin
         run_bist(2'($urandom_range(3, 0)), 1'b0, dc);
         chk("rnd_done_cyc", dc, 21);
         chk("rnd_pass", pass, 1);
         @(negedge clk);
      end

      // wide config, bit0 stuck at 0 everywhere: 256 up-mismatches
      start_w = 1'b1; pattern_w = 2'b01;
      @(negedge clk);
      start_w = 1'b0;
      dc = -1;
      for (int c = 1; c <= 1400; c++) begin
         if (done_w) begin
            dc = c;
            break;
         end
         @(negedge clk);
      end
      chk("sat_done_seen", (dc > 0), 1);
      chk("sat_err", err_cnt_w, exp_sat);
      chk("sat_pass", pass_w, 0);
      chk("sat_fail_addr", fail_addr_w, 0);
      @(negedge clk);
      chk("sat_err_held", err_cnt_w, exp_sat);

      chk("proto_wr_rd_overlap", proto_viol, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
